// File: rtl/ysyx_23060075_csr_seq_if.sv
// ysyx_23060075_csr_seq_if: EXU-side request/response bundle for the CSR sequencer
interface ysyx_23060075_csr_seq_if #(
  parameter int ISA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [CSR_ADDR_WIDTH-1:0] req_addr;
  logic [ISA_WIDTH-1:0] req_src;
  logic [ISA_WIDTH-1:0] req_pc;
  logic resp_valid;
  logic [ISA_WIDTH-1:0] resp_rdata;
  logic redirect_en;
  logic [ISA_WIDTH-1:0] redirect_pc;
  modport master (
    output req_valid, req_op, req_addr, req_src, req_pc,
    input req_ready, resp_valid, resp_rdata, redirect_en, redirect_pc
  );
  modport slave (
    input req_valid, req_op, req_addr, req_src, req_pc,
    output req_ready, resp_valid, resp_rdata, redirect_en, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060075_csr_seq.sv
// ysyx_23060075_csr_seq: sequences CSRRW/CSRRS/ECALL/MRET onto the single-port machine CSR file
module ysyx_23060075_csr_seq #(
  parameter int ISA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int MCAUSE_ECALL = 11
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060075_csr_seq_if.slave s,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [ISA_WIDTH-1:0] csr_w,
  output logic csr_w_en,
  input  logic [ISA_WIDTH-1:0] csr_r
);
  localparam logic [1:0] OP_RS = 2'd1;
  localparam logic [1:0] OP_ECALL = 2'd2;
  localparam logic [1:0] OP_MRET = 2'd3;
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE = CSR_ADDR_WIDTH'(12'h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC = CSR_ADDR_WIDTH'(12'h305);
  typedef enum logic [2:0] {IDLE, RD, WR, EPC, CAUSE, VEC, MEPC, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [CSR_ADDR_WIDTH-1:0] addr;
  logic [ISA_WIDTH-1:0] src;
  logic [ISA_WIDTH-1:0] old;
  // Outputs are registered: each transition loads the values belonging to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      src <= '0;
      old <= '0;
      s.req_ready <= 1'b0;
      s.resp_valid <= 1'b0;
      s.resp_rdata <= '0;
      s.redirect_en <= 1'b0;
      s.redirect_pc <= '0;
      csr_addr <= '0;
      csr_w <= '0;
      csr_w_en <= 1'b0;
    end else begin
      s.req_ready <= 1'b0;
      s.resp_valid <= 1'b0;
      s.resp_rdata <= '0;
      s.redirect_en <= 1'b0;
      s.redirect_pc <= '0;
      csr_addr <= '0;
      csr_w <= '0;
      csr_w_en <= 1'b0;
      case (state)
        IDLE: if (s.req_valid && s.req_ready) begin
          op <= s.req_op;
          addr <= s.req_addr;
          src <= s.req_src;
          state <= s.req_op == OP_ECALL ? EPC : s.req_op == OP_MRET ? MEPC : RD;
          csr_addr <= s.req_op == OP_ECALL || s.req_op == OP_MRET ? A_MEPC : s.req_addr;
          csr_w <= s.req_op == OP_ECALL ? s.req_pc & ~ISA_WIDTH'(3) : '0;
          csr_w_en <= s.req_op == OP_ECALL;
        end else s.req_ready <= 1'b1;
        RD: begin
          old <= csr_r;
          state <= WR;
          csr_addr <= addr;
          csr_w <= op == OP_RS ? csr_r | src : src;
          csr_w_en <= op != OP_RS || src != '0;
        end
        WR: begin
          state <= DONE;
          s.resp_valid <= 1'b1;
          s.resp_rdata <= old;
        end
        EPC: begin
          state <= CAUSE;
          csr_addr <= A_MCAUSE;
          csr_w <= ISA_WIDTH'(MCAUSE_ECALL);
          csr_w_en <= 1'b1;
        end
        CAUSE: begin
          state <= VEC;
          csr_addr <= A_MTVEC;
        end
        VEC, MEPC: begin
          state <= DONE;
          s.resp_valid <= 1'b1;
          s.redirect_en <= 1'b1;
          s.redirect_pc <= csr_r;
        end
        DONE: begin
          state <= IDLE;
          s.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060075_csr_seq.sv
// tb_ysyx_23060075_csr_seq: directed stimulus with a CSR-file model and response/write scoreboards
module tb_ysyx_23060075_csr_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ysyx_23060075_csr_seq_if bus();
  logic [11:0] csr_addr;
  logic [31:0] csr_w;
  logic [31:0] csr_r;
  logic csr_w_en;
  ysyx_23060075_csr_seq dut (
    .clk(clk), .rst(rst), .s(bus),
    .csr_addr(csr_addr), .csr_w(csr_w), .csr_w_en(csr_w_en), .csr_r(csr_r)
  );
  logic [31:0] f_mepc = 32'h0, f_mcause = 32'h0, f_mtvec = 32'h0, f_mstatus = 32'h1800;
  always_comb csr_r = csr_addr == 12'h341 ? f_mepc : csr_addr == 12'h342 ? f_mcause :
                      csr_addr == 12'h305 ? f_mtvec : csr_addr == 12'h300 ? f_mstatus : 32'h0;
  always @(posedge clk) if (csr_w_en) begin
    if (csr_addr == 12'h341) f_mepc <= csr_w;
    if (csr_addr == 12'h342) f_mcause <= csr_w;
    if (csr_addr == 12'h305) f_mtvec <= csr_w;
    if (csr_addr == 12'h300) f_mstatus <= csr_w;
  end
  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] rdata; logic ren; logic [31:0] rpc; int stamp; int lat; } resp_t;
  wr_t wq[$];
  resp_t rq[$];
  logic [31:0] m_mepc = 32'h0, m_mcause = 32'h0, m_mtvec = 32'h0, m_mstatus = 32'h1800;
  int cyc = 0, checks = 0, passed = 0, nwr = 0, nresp = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] mrd(input logic [11:0] a);
    return a == 12'h341 ? m_mepc : a == 12'h342 ? m_mcause : a == 12'h305 ? m_mtvec :
           a == 12'h300 ? m_mstatus : 32'h0;
  endfunction
  task automatic mwr(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h341) m_mepc = d;
    if (a == 12'h342) m_mcause = d;
    if (a == 12'h305) m_mtvec = d;
    if (a == 12'h300) m_mstatus = d;
  endtask
  always @(posedge clk) begin
    logic [31:0] o;
    cyc++;
    if (rst && bus.req_valid && bus.req_ready) begin
      o = mrd(bus.req_addr);
      case (bus.req_op)
        2'd0: begin
          wq.push_back('{bus.req_addr, bus.req_src});
          rq.push_back('{o, 1'b0, 32'h0, cyc, 3});
          mwr(bus.req_addr, bus.req_src);
        end
        2'd1: begin
          if (bus.req_src != 0) begin
            wq.push_back('{bus.req_addr, o | bus.req_src});
            mwr(bus.req_addr, o | bus.req_src);
          end
          rq.push_back('{o, 1'b0, 32'h0, cyc, 3});
        end
        2'd2: begin
          wq.push_back('{12'h341, bus.req_pc & 32'hffff_fffc});
          wq.push_back('{12'h342, 32'd11});
          m_mepc = bus.req_pc & 32'hffff_fffc;
          m_mcause = 32'd11;
          rq.push_back('{32'h0, 1'b1, m_mtvec, cyc, 4});
        end
        default: rq.push_back('{32'h0, 1'b1, m_mepc, cyc, 2});
      endcase
    end
  end
  always @(negedge clk) if (rst) begin
    wr_t w;
    resp_t r;
    if (csr_w_en) begin
      nwr++;
      chk("wr_expected", 64'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("wr_addr", csr_addr, w.a);
        chk("wr_data", csr_w, w.d);
      end
    end
    if (bus.redirect_en) chk("redir_with_resp", bus.resp_valid, 1);
    if (bus.resp_valid) begin
      nresp++;
      chk("resp_expected", 64'(rq.size() > 0), 1);
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk("resp_rdata", bus.resp_rdata, r.rdata);
        chk("redirect_en", bus.redirect_en, r.ren);
        chk("redirect_pc", bus.redirect_pc, r.rpc);
        chk("resp_latency", 64'(cyc - r.stamp + 1), 64'(r.lat));
      end
    end
  end
  task automatic send(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src, input logic [31:0] pc);
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_src = src;
    bus.req_pc = pc;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    chk("accept_ready", bus.req_ready, 1);
    @(negedge clk);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && rq.size() != 0; i++) @(negedge clk);
    chk("drain", rq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int n, w0, r0;
    bus.req_valid = 1'b0;
    bus.req_op = 2'd0;
    bus.req_addr = 12'h0;
    bus.req_src = 32'h0;
    bus.req_pc = 32'h0;
    #12;
    chk("rst_ctrl", {bus.req_ready, bus.resp_valid, bus.redirect_en, csr_w_en}, 0);
    chk("rst_data", bus.resp_rdata | bus.redirect_pc | csr_w | {20'h0, csr_addr}, 0);
    @(negedge clk);
    rst = 1'b1;
    chk("ready_before_edge", bus.req_ready, 0);
    @(negedge clk);
    chk("ready_after_release", bus.req_ready, 1);
    w0 = nwr;
    send(2'd0, 12'h305, 32'h8000_0100, 32'h0);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("rw_busy_cycles", n, 3);
    chk("rw_write_count", nwr - w0, 1);
    chk("mtvec_readback", f_mtvec, 32'h8000_0100);
    w0 = nwr;
    send(2'd1, 12'h300, 32'h0, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    chk("rs_zero_no_write", nwr - w0, 0);
    send(2'd1, 12'h300, 32'h8, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    chk("mstatus_set", f_mstatus, 32'h1808);
    send(2'd2, 12'h0, 32'h0, 32'h8000_0040);
    bus.req_valid = 1'b0;
    drain();
    chk("ecall_mepc", f_mepc, 32'h8000_0040);
    chk("ecall_mcause", f_mcause, 32'd11);
    w0 = nwr;
    send(2'd3, 12'h0, 32'h0, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    chk("mret_no_write", nwr - w0, 0);
    r0 = nresp;
    send(2'd0, 12'h341, 32'h8000_0200, 32'h0);
    send(2'd2, 12'h0, 32'h0, 32'h8000_0047);
    send(2'd1, 12'h300, 32'h80, 32'h0);
    send(2'd3, 12'h0, 32'h0, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    chk("b2b_resp_count", nresp - r0, 4);
    chk("b2b_mepc_aligned", f_mepc, 32'h8000_0044);
    chk("b2b_mstatus", f_mstatus, 32'h1888);
    send(2'd0, 12'h7c0, 32'hdead, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    send(2'd0, 12'h342, 32'h0, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    w0 = nwr;
    r0 = nresp;
    send(2'd2, 12'h0, 32'h0, 32'h8000_0080);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("cause_state_addr", csr_addr, 12'h342);
    chk("cause_state_wen", csr_w_en, 1);
    rst = 1'b0;
    #1;
    chk("abort_ctrl", {bus.req_ready, bus.resp_valid, bus.redirect_en, csr_w_en}, 0);
    chk("abort_data", bus.resp_rdata | bus.redirect_pc | csr_w | {20'h0, csr_addr}, 0);
    wq.delete();
    rq.delete();
    m_mcause = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_ready_low", bus.req_ready, 0);
    @(negedge clk);
    chk("abort_ready_high", bus.req_ready, 1);
    chk("abort_mcause_kept", f_mcause, 32'h0);
    chk("abort_mepc_written", f_mepc, 32'h8000_0080);
    chk("abort_write_count", nwr - w0, 1);
    chk("abort_no_resp", nresp - r0, 0);
    send(2'd3, 12'h0, 32'h0, 32'h0);
    bus.req_valid = 1'b0;
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
